// File: rtl/mem_pkg.sv
// Shared encodings for the two-master RAM arbiter: memory commands,
// arbiter FSM states and requester identities.
package mem_pkg;

   typedef enum logic [1:0] {
      MNONE  = 2'b00,
      MREAD  = 2'b01,
      MWRITE = 2'b10
   } mem_cmd_t;

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      ACCESS = 2'b01,
      RESP   = 2'b10
   } arb_state_t;

   localparam logic OWNER_CPU = 1'b0;
   localparam logic OWNER_DMA = 1'b1;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the CPU/DMA requesters, the arbiter and the RAM.
// The slave modport is the arbiter's view; master is the environment's view.
interface mem_arbiter_if #(
   parameter int ADDR_W = 9,
   parameter int DATA_W = 16
);

   logic              cpu_req;
   logic [1:0]        cpu_cmd;
   logic [ADDR_W-1:0] cpu_addr;
   logic [DATA_W-1:0] cpu_wdata;
   logic              cpu_ack;
   logic [DATA_W-1:0] cpu_rdata;

   logic              dma_req;
   logic [1:0]        dma_cmd;
   logic [ADDR_W-1:0] dma_addr;
   logic [DATA_W-1:0] dma_wdata;
   logic              dma_ack;
   logic [DATA_W-1:0] dma_rdata;

   logic [ADDR_W-1:0] ram_addr;
   logic              ram_write;
   logic [DATA_W-1:0] ram_din;
   logic [DATA_W-1:0] ram_dout;

   logic              busy;
   logic              owner;

   modport slave (
      input  cpu_req, cpu_cmd, cpu_addr, cpu_wdata,
      input  dma_req, dma_cmd, dma_addr, dma_wdata,
      input  ram_dout,
      output cpu_ack, cpu_rdata, dma_ack, dma_rdata,
      output ram_addr, ram_write, ram_din, busy, owner
   );

   modport master (
      output cpu_req, cpu_cmd, cpu_addr, cpu_wdata,
      output dma_req, dma_cmd, dma_addr, dma_wdata,
      output ram_dout,
      input  cpu_ack, cpu_rdata, dma_ack, dma_rdata,
      input  ram_addr, ram_write, ram_din, busy, owner
   );

endinterface

// File: rtl/mem_arbiter_rr_pick.sv
// Combinational two-way winner select. Round-robin on ties by default;
// defining ARB_CPU_PRIORITY_EN makes the CPU win every tie instead.
module rr_pick
   import mem_pkg::*;
(
   input  logic i_cpu_req,
   input  logic i_dma_req,
   input  logic i_last_grant,
   output logic o_grant,
   output logic o_pick
);

`ifdef ARB_CPU_PRIORITY_EN
   logic w_unused_last_grant;
   assign w_unused_last_grant = i_last_grant;
`endif

   // NOTE: every output gets a default before any branch so no latch is inferred.
   always_comb begin
      o_grant = i_cpu_req | i_dma_req;
      o_pick  = OWNER_CPU;
      if (i_cpu_req && i_dma_req) begin
`ifdef ARB_CPU_PRIORITY_EN
         o_pick = OWNER_CPU;
`else
         o_pick = (i_last_grant == OWNER_CPU) ? OWNER_DMA : OWNER_CPU;
`endif
      end else if (i_dma_req) begin
         o_pick = OWNER_DMA;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Serialises CPU and DMA accesses onto one synchronous single-port RAM
// (IDLE -> ACCESS -> RESP). Tie policy selected by ARB_CPU_PRIORITY_EN.
module mem_arbiter
   import mem_pkg::*;
#(
   parameter int ADDR_W = 9,
   parameter int DATA_W = 16
) (
   input logic          clk,
   input logic          reset,
   mem_arbiter_if.slave bus
);

   arb_state_t        r_state;
   arb_state_t        w_state_nxt;
   logic [1:0]        r_cmd;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_wdata;
   logic              r_owner;
   logic              r_last_grant;
   logic [DATA_W-1:0] r_cpu_rdata;
   logic [DATA_W-1:0] r_dma_rdata;

   logic              w_grant;
   logic              w_pick;
   logic              w_take;
   logic [ADDR_W-1:0] w_sel_addr;

   rr_pick u_rr_pick (
      .i_cpu_req    (bus.cpu_req),
      .i_dma_req    (bus.dma_req),
      .i_last_grant (r_last_grant),
      .o_grant      (w_grant),
      .o_pick       (w_pick)
   );

   assign w_take     = (r_state == IDLE) && w_grant && reset;
   assign w_sel_addr = (w_pick == OWNER_DMA) ? bus.dma_addr : bus.cpu_addr;

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         IDLE:    if (w_take) w_state_nxt = ACCESS;
         ACCESS:  w_state_nxt = RESP;
         RESP:    w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= IDLE;
      else        r_state <= w_state_nxt;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_cmd        <= MNONE;
         r_addr       <= '0;
         r_wdata      <= '0;
         r_owner      <= OWNER_CPU;
         r_last_grant <= OWNER_DMA;
      end else if (w_take) begin
         r_owner      <= w_pick;
         r_last_grant <= w_pick;
         r_addr       <= w_sel_addr;
         r_cmd        <= (w_pick == OWNER_DMA) ? bus.dma_cmd   : bus.cpu_cmd;
         r_wdata      <= (w_pick == OWNER_DMA) ? bus.dma_wdata : bus.cpu_wdata;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_cpu_rdata <= '0;
         r_dma_rdata <= '0;
      end else if (r_state == ACCESS && r_cmd == MREAD) begin
         if (r_owner == OWNER_DMA) r_dma_rdata <= bus.ram_dout;
         else                      r_cpu_rdata <= bus.ram_dout;
      end
   end

   // The winner's address is shown to the RAM in the grant cycle so its
   // registered read data is already valid throughout ACCESS.
   assign bus.ram_addr  = w_take ? w_sel_addr : r_addr;
   assign bus.ram_din   = r_wdata;
   assign bus.ram_write = (r_state == ACCESS) && (r_cmd == MWRITE);

   assign bus.cpu_ack   = (r_state == RESP) && (r_owner == OWNER_CPU);
   assign bus.dma_ack   = (r_state == RESP) && (r_owner == OWNER_DMA);
   assign bus.cpu_rdata = r_cpu_rdata;
   assign bus.dma_rdata = r_dma_rdata;
   assign bus.busy      = (r_state != IDLE);
   assign bus.owner     = r_owner;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: RAM stub, transaction-level model with a
// per-cycle compare process, and literal expectations for each scenario.
module tb_mem_arbiter;
   import mem_pkg::*;

   localparam int ADDR_W = 9;
   localparam int DATA_W = 16;
   localparam int DEPTH  = 1 << ADDR_W;

   logic clk;
   logic reset;

   mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [DATA_W-1:0] init_word(input int i);
      logic [DATA_W-1:0] v;
      v = DATA_W'(i * 16'h0123) ^ 16'h5A5A;
      return v;
   endfunction

   // RAM stub: synchronous read (old data on same-address write), write on edge.
   logic [DATA_W-1:0] tb_ram [DEPTH];
   always @(posedge clk) begin
      if (bus.ram_write) tb_ram[bus.ram_addr] <= bus.ram_din;
      bus.ram_dout <= tb_ram[bus.ram_addr];
   end

   // Transaction-level model: m_age counts cycles since a grant (0 = no transaction).
   logic [DATA_W-1:0] exp_mem [DEPTH];
   int                m_age;
   logic              m_last, m_owner, m_who;
   logic [1:0]        m_cmd;
   logic [ADDR_W-1:0] m_addr;
   logic [DATA_W-1:0] m_wdata, m_cpu_rd, m_dma_rd;

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_age    = 0;
         m_last   = OWNER_DMA;
         m_owner  = OWNER_CPU;
         m_cmd    = 2'b00;
         m_addr   = '0;
         m_wdata  = '0;
         m_cpu_rd = '0;
         m_dma_rd = '0;
      end else if (m_age == 2) begin
         m_age = 0;
      end else if (m_age == 1) begin
         m_age = 2;
         if (m_cmd == MWRITE) exp_mem[m_addr] = m_wdata;
         else if (m_cmd == MREAD) begin
            if (m_owner == OWNER_DMA) m_dma_rd = exp_mem[m_addr];
            else                      m_cpu_rd = exp_mem[m_addr];
         end
      end else if (bus.cpu_req || bus.dma_req) begin
         if (bus.cpu_req && bus.dma_req) begin
`ifdef ARB_CPU_PRIORITY_EN
            m_who = OWNER_CPU;
`else
            m_who = (m_last == OWNER_CPU) ? OWNER_DMA : OWNER_CPU;
`endif
         end else begin
            m_who = bus.dma_req ? OWNER_DMA : OWNER_CPU;
         end
         m_owner = m_who;
         m_last  = m_who;
         m_cmd   = m_who ? bus.dma_cmd   : bus.cpu_cmd;
         m_addr  = m_who ? bus.dma_addr  : bus.cpu_addr;
         m_wdata = m_who ? bus.dma_wdata : bus.cpu_wdata;
         m_age   = 1;
      end
   end

   always @(negedge clk) begin
      if (reset) begin
         check("busy", 32'(bus.busy), 32'(m_age != 0));
         check("owner", 32'(bus.owner), 32'(m_owner));
         check("cpu_ack", 32'(bus.cpu_ack), 32'(m_age == 2 && m_owner == OWNER_CPU));
         check("dma_ack", 32'(bus.dma_ack), 32'(m_age == 2 && m_owner == OWNER_DMA));
         check("ram_write", 32'(bus.ram_write), 32'(m_age == 1 && m_cmd == MWRITE));
         check("cpu_rdata", 32'(bus.cpu_rdata), 32'(m_cpu_rd));
         check("dma_rdata", 32'(bus.dma_rdata), 32'(m_dma_rd));
         check("ack_exclusive", 32'(bus.cpu_ack && bus.dma_ack), 32'd0);
         if (m_age == 1) begin
            check("ram_addr", 32'(bus.ram_addr), 32'(m_addr));
            check("ram_din", 32'(bus.ram_din), 32'(m_wdata));
         end
      end
   end

   // Single requester transaction; returns data, owner at ack and edge latency.
   task automatic txn(input logic who, input logic [1:0] cmd, input logic [ADDR_W-1:0] addr,
                      input logic [DATA_W-1:0] wdata, output logic [DATA_W-1:0] rdata,
                      output logic own, output int edges);
      logic got;
      got = 1'b0;
      edges = 0;
      rdata = '0;
      own = 1'b0;
      if (who == OWNER_DMA) begin
         bus.dma_req = 1'b1; bus.dma_cmd = cmd; bus.dma_addr = addr; bus.dma_wdata = wdata;
      end else begin
         bus.cpu_req = 1'b1; bus.cpu_cmd = cmd; bus.cpu_addr = addr; bus.cpu_wdata = wdata;
      end
      for (int i = 0; i < 20 && !got; i++) begin
         @(posedge clk);
         edges++;
         @(negedge clk);
         if (who == OWNER_DMA ? bus.dma_ack : bus.cpu_ack) begin
            got   = 1'b1;
            rdata = (who == OWNER_DMA) ? bus.dma_rdata : bus.cpu_rdata;
            own   = bus.owner;
         end
      end
      if (!got) check("ack_timeout", 32'd0, 32'd1);
      @(posedge clk);
      #1;
      check("ack_single_pulse", 32'(bus.cpu_ack | bus.dma_ack), 32'd0);
      bus.cpu_req = 1'b0;
      bus.dma_req = 1'b0;
   endtask

   // Both requesters held high; records which one each ack belongs to.
   task automatic contend(input int n, output logic [7:0] order);
      int k;
      k = 0;
      order = '0;
      bus.cpu_req = 1'b1; bus.cpu_cmd = MREAD; bus.cpu_addr = 9'h005;
      bus.dma_req = 1'b1; bus.dma_cmd = MREAD; bus.dma_addr = 9'h010;
      for (int i = 0; i < 10 * n && k < n; i++) begin
         @(negedge clk);
         if (bus.cpu_ack)      begin order[k] = OWNER_CPU; k++; end
         else if (bus.dma_ack) begin order[k] = OWNER_DMA; k++; end
      end
      check("contend_ack_count", 32'(k), 32'(n));
      @(posedge clk);
      #1;
      bus.cpu_req = 1'b0;
      bus.dma_req = 1'b0;
   endtask

   logic [DATA_W-1:0] rd;
   logic              own;
   int                lat;
   logic [7:0]        order;
   logic              wr_seen;

   initial begin
      reset = 1'b0;
      bus.cpu_req = 1'b0; bus.cpu_cmd = MNONE; bus.cpu_addr = '0; bus.cpu_wdata = '0;
      bus.dma_req = 1'b0; bus.dma_cmd = MNONE; bus.dma_addr = '0; bus.dma_wdata = '0;
      for (int i = 0; i < DEPTH; i++) begin
         tb_ram[i]  <= init_word(i);
         exp_mem[i]  = init_word(i);
      end
      tb_ram[5]  <= 16'h97BC;
      exp_mem[5]  = 16'h97BC;
      #1;
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_acks", 32'({bus.cpu_ack, bus.dma_ack}), 32'd0);
      check("rst_ram_write", 32'(bus.ram_write), 32'd0);
      check("rst_ram_addr", 32'(bus.ram_addr), 32'd0);
      check("rst_ram_din", 32'(bus.ram_din), 32'd0);
      check("rst_owner", 32'(bus.owner), 32'd0);
      check("rst_rdata", 32'({bus.cpu_rdata, bus.dma_rdata}), 32'd0);
      repeat (3) @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;

      txn(OWNER_CPU, MREAD, 9'h005, 16'h0000, rd, own, lat);
      check("cpu_rd_data", 32'(rd), 32'h97BC);
      check("cpu_rd_latency", 32'(lat), 32'd2);
      check("cpu_rd_owner", 32'(own), 32'd0);

      txn(OWNER_CPU, MWRITE, 9'h010, 16'h0007, rd, own, lat);
      check("cpu_wr_latency", 32'(lat), 32'd2);
      txn(OWNER_DMA, MREAD, 9'h010, 16'h0000, rd, own, lat);
      check("dma_rd_data", 32'(rd), 32'h0007);
      check("dma_rd_owner", 32'(own), 32'd1);

      contend(4, order);
`ifdef ARB_CPU_PRIORITY_EN
      check("contend_order", 32'(order[3:0]), 32'h0);
`else
      check("contend_order", 32'(order[3:0]), 32'b1010);
`endif
      check("contend_cpu_rdata", 32'(bus.cpu_rdata), 32'h97BC);
      check("contend_dma_rdata", 32'(bus.dma_rdata), 32'h0007);

      wr_seen = 1'b0;
      fork
         txn(OWNER_DMA, MNONE, 9'h020, 16'hFFFF, rd, own, lat);
         repeat (6) begin @(negedge clk); wr_seen |= bus.ram_write; end
      join
      check("mnone_no_write", 32'(wr_seen), 32'd0);
      check("mnone_rdata", 32'(bus.dma_rdata), 32'h0007);
      check("mnone_ram", 32'(tb_ram[9'h020]), 32'(init_word(9'h020)));

      txn(OWNER_CPU, 2'b11, 9'h005, 16'h1234, rd, own, lat);
      check("cmd11_rdata", 32'(bus.cpu_rdata), 32'h97BC);
      check("cmd11_ram", 32'(tb_ram[9'h005]), 32'h97BC);

      // Abort a CPU write while it is in its ACCESS cycle.
      bus.cpu_req = 1'b1; bus.cpu_cmd = MWRITE; bus.cpu_addr = 9'h040; bus.cpu_wdata = 16'hDEAD;
      @(posedge clk);
      #2;
      check("pre_abort_write", 32'(bus.ram_write), 32'd1);
      reset = 1'b0;
      #1;
      check("abort_ram_write", 32'(bus.ram_write), 32'd0);
      check("abort_busy", 32'(bus.busy), 32'd0);
      check("abort_ack", 32'(bus.cpu_ack), 32'd0);
      check("abort_ram_addr", 32'(bus.ram_addr), 32'd0);
      bus.cpu_req = 1'b0;
      repeat (2) @(posedge clk);
      check("abort_ack_held", 32'(bus.cpu_ack), 32'd0);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      check("abort_ram_unchanged", 32'(tb_ram[9'h040]), 32'(init_word(9'h040)));
      txn(OWNER_CPU, MREAD, 9'h040, 16'h0000, rd, own, lat);
      check("abort_readback", 32'(rd), 32'(init_word(9'h040)));

      // Reset leaves last_grant at DMA, so the CPU wins the next tie.
      reset = 1'b0;
      #3;
      reset = 1'b1;
      @(posedge clk);
      #1;
      contend(2, order);
`ifdef ARB_CPU_PRIORITY_EN
      check("post_rst_order", 32'(order[1:0]), 32'b00);
`else
      check("post_rst_order", 32'(order[1:0]), 32'b10);
`endif

      repeat (3) @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule
